serial_addsub_ctrl: RTL and testbench
=====================================

Name: serial_addsub_ctrl

Overview:
- Bit-serial adder/subtractor sequencer.
- Owns one 1-bit full-adder cell and steps two WIDTH-bit operands through it LSB-first, one bit per clock.
- Offers a start/busy/done handshake toward the board-level controller (switch/button front end), plus registered result, carry and signed-overflow flags.
- Trades latency (WIDTH cycles) for minimal FPGA adder logic.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk, input, 1, rising-edge system clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request to begin an operation; sampled only in IDLE.
- sub, input, 1, 0 = add (a+b), 1 = subtract (a−b); sampled with start.
- a, input, WIDTH, operand A; sampled with start.
- b, input, WIDTH, operand B; sampled with start.
- busy, output, 1, high in RUN and DONE.
- done, output, 1, one-cycle pulse; result, cout and ovf are valid from this cycle on.
- result, output, WIDTH, registered sum/difference.
- cout, output, 1, final carry out; for subtract, 1 = no borrow (a ≥ b unsigned).
- ovf, output, 1, signed two's-complement overflow.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0; internal shift regs, carry and bit counter are cleared.
- Clock and reset: single clock domain; reset is asynchronous and active-high.
- FSM states: IDLE, RUN, DONE; 2-bit encoding.
- IDLE:
  - if start=1 at edge T: latch opA=a, opB = sub ? ~b : b, carry=sub, cnt=0, scratch result=0; go to RUN.
  - busy rises after edge T.
  - result, cout and ovf keep their previous values until the new done.
- RUN: each edge T+1..T+WIDTH:
  - s = opA[0]^opB[0]^carry; c = majority(opA[0], opB[0], carry).
  - shift s into scratch MSB, shifting right.
  - shift opA and opB right by 1; carry=c; cnt++.
  - on the edge processing bit WIDTH−1:
    - capture carry-into-MSB (cmsb) = carry before update;
    - commit result = final scratch, cout = c, ovf = cmsb ^ c;
    - go to DONE.
- DONE: done=1 for exactly one cycle (cycle after edge T+WIDTH), busy=1; next edge returns to IDLE.
- Latency: done is observed WIDTH cycles after the start-accept edge; throughput is one operation per WIDTH+2 cycles.
- start while busy=1 (RUN or DONE) is ignored, not queued; a/b/sub changes during RUN have no effect.
- start held high continuously: a new operation is accepted on the first IDLE cycle after DONE.
- Counter: $clog2(WIDTH)+1 bits wide; terminal compare is cnt==WIDTH−1; no wrap is reachable.
- Reset asserted mid-RUN aborts immediately and returns to reset values; no done pulse is produced.
- Arithmetic: result = (a ± b) mod 2^WIDTH.

Optional Feature:
- Macro: SERIAL_ADDSUB_SAT_EN.
- Defined: on commit, if ovf=1, result saturates to the signed limit:
  - 0111…1 when the true result is positive (opA MSB=0);
  - 1000…0 when negative.
  - ovf still reports 1; cout is unchanged.
- Undefined: result wraps modulo 2^WIDTH; no saturation logic is synthesized.

Decomposition:
- Package serial_addsub_pkg holds:
  - FSM state typedef (ST_IDLE, ST_RUN, ST_DONE);
  - localparam helpers for counter width;
  - SAT_POS/SAT_NEG constant functions of WIDTH.
- Sub-module: one instance of the existing 1-bit full-adder cell (fulladder: A, B, Cin → Sum, Cout), driven by opA[0], opB[0] and carry.
- All sequencing stays in serial_addsub_ctrl.

Test Plan:
- WIDTH=8, add, a=0x05, b=0x03 → done pulse 8 cycles after accept; result=0x08, cout=0, ovf=0; busy high 9 cycles.
- Subtract, a=0x03, b=0x05 → result=0xFE, cout=0 (borrow), ovf=0. Subtract, a=0x05, b=0x03 → result=0x02, cout=1.
- Add, a=0x7F, b=0x01 → ovf=1, cout=0; result=0x80 without SAT_EN, 0x7F with SAT_EN. Subtract, a=0x80, b=0x01 → ovf=1; result=0x7F without SAT_EN, 0x80 with SAT_EN.
- Add, a=0xFF, b=0x01 → result=0x00, cout=1, ovf=0.
- Pulse start again at cycles 3 and 8 of a running op with different operands → ignored, first result intact, exactly one done; start held high → back-to-back ops spaced 10 cycles.
- Assert rst at RUN cycle 4 → busy=0, result=0, no done; next start with 0x10+0x20 → 0x30 normally.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared FSM state type, counter sizing and saturation limits for the serial add/sub sequencer.
package serial_addsub_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  function automatic logic [31:0] sat_pos(input int w);
    return (32'h1 << (w - 1)) - 32'h1;
  endfunction

  function automatic logic [31:0] sat_neg(input int w);
    return 32'h1 << (w - 1);
  endfunction

endpackage

// File: rtl/fulladder.sv
// fulladder: 1-bit full-adder cell shared by the serial sequencer.
module fulladder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: LSB-first bit-serial adder/subtractor with start/busy/done handshake.
// Build with SERIAL_ADDSUB_SAT_EN defined to saturate the result on signed overflow.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = cnt_w(WIDTH);
`ifdef SERIAL_ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_P = WIDTH'(sat_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_N = WIDTH'(sat_neg(WIDTH));
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, scr_q, scr_d, result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             s, c;

  fulladder u_fa (
    .A   (opa_q[0]),
    .B   (opb_q[0]),
    .Cin (carry_q),
    .Sum (s),
    .Cout(c)
  );

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    scr_d    = scr_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: if (start) begin
        opa_d   = a;
        opb_d   = sub ? ~b : b;
        carry_d = sub;
        cnt_d   = '0;
        scr_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        scr_d   = {s, scr_q[WIDTH-1:1]};
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q here is the carry into the MSB
          cout_d   = c;
          ovf_d    = carry_q ^ c;
`ifdef SERIAL_ADDSUB_SAT_EN
          result_d = (carry_q ^ c) ? (opa_q[0] ? SAT_N : SAT_P) : scr_d;
`else
          result_d = scr_d;
`endif
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      scr_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      scr_q    <= scr_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = state_q != ST_IDLE;
  assign done   = state_q == ST_DONE;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb_serial_addsub_ctrl: directed self-checking bench for serial_addsub_ctrl at WIDTH=8.
module tb_serial_addsub_ctrl;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout, ovf;
  logic [7:0] result;
  int         n_cmp = 0, n_err = 0;
  logic [7:0] prev_res = '0;

  serial_addsub_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic sv,
                       input logic [7:0] er, input logic ec, input logic eo, input bit glitch);
    int bcnt = 0, dcnt = 0, dat = 0;
    a = av; b = bv; sub = sv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin dcnt++; if (dat == 0) dat = i; end
      if (busy) bcnt++;
      if (i == 1) chk({tag, "_hold"}, result, prev_res);
      start = glitch && (i == 3 || i == 8);
      if (glitch) begin a = 8'h11; b = 8'h22; sub = ~sv; end
    end
    chk({tag, "_done_at"}, dat, 9);
    chk({tag, "_done_cnt"}, dcnt, 1);
    chk({tag, "_busy_cnt"}, bcnt, 9);
    chk({tag, "_result"}, result, er);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    prev_res = er;
  endtask

  initial begin
    int d1, d2, dn;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    do_op("add_5_3", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 0);
    do_op("sub_3_5", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
    do_op("sub_5_3", 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 0);
`ifdef SERIAL_ADDSUB_SAT_EN
    do_op("add_7f_1", 8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
    do_op("sub_80_1", 8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1, 0);
`else
    do_op("add_7f_1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    do_op("sub_80_1", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
`endif
    do_op("add_ff_1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    do_op("glitch", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1);
    // start held high: accepts again on the first IDLE cycle after DONE
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    d1 = 0; d2 = 0; dn = 0;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        if (d1 == 0) d1 = i; else if (d2 == 0) d2 = i;
        chk("held_result", result, 8'h46);
      end
    end
    start = 1'b0;
    chk("held_done_cnt", dn, 2);
    chk("held_spacing", d2 - d1, 10);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    chk("held_drain", busy, 0);
    // reset in the middle of RUN
    a = 8'h55; b = 8'h11; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("mid_rst_no_done", dn, 0);
    prev_res = 8'h00;
    do_op("after_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
